addsub_4bit_bist: RTL and testbench

Sequential built-in self-test engine for the 4-bit adder/subtractor. It sits on the operand side of that block, and drives `a`, `b` and `mode` into it. It sweeps all 512 input combinations, samples `result`/`cout` back, and compares them against an internal golden model. It reports pass/fail, an error count and the first failing vector, so the adder/subtractor can be checked in silicon or on an FPGA without a simulator.

---
 rtl/addsub_4bit_bist_if.sv | 30 +++
 rtl/addsub_4bit_bist.sv | 112 +++++++++++
 tb/tb_addsub_4bit_bist.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_4bit_bist_if.sv
// Operand/response and status bundle between the BIST engine
// and the 4-bit adder/subtractor under test.
interface addsub_4bit_bist_if;
  logic       start;
  logic [3:0] result_in;
  logic       cout_in;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic       mode_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [9:0] err_count;
  logic       first_fail_valid;
  logic [8:0] first_fail_vec;

  modport master (
    input  start, result_in, cout_in,
    output a_out, b_out, mode_out,
    output busy, done, pass, err_count,
    output first_fail_valid, first_fail_vec
  );

  modport slave (
    output start, result_in, cout_in,
    input  a_out, b_out, mode_out,
    input  busy, done, pass, err_count,
    input  first_fail_valid, first_fail_vec
  );
endinterface

// File: rtl/addsub_4bit_bist.sv
// Exhaustive self-test sweep for a 4-bit adder/subtractor:
// drives all 512 {mode,a,b} vectors and checks result/cout.
module addsub_4bit_bist #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  addsub_4bit_bist_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [8:0] r_vec;
  logic [3:0] r_settle;
  logic [9:0] r_err;
  logic       r_ffv;
  logic [8:0] r_ffvec;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;

  logic [4:0] w_exp;
  logic       w_mis;
  logic [9:0] w_err_nxt;

  always_comb begin
    w_exp = 5'd0;
    if (r_vec[8])
      w_exp = {1'b0, r_vec[7:4]} + {1'b0, ~r_vec[3:0]} + 5'd1;
    else
      w_exp = {1'b0, r_vec[7:4]} + {1'b0, r_vec[3:0]};
  end

  assign w_mis = ({bus.cout_in, bus.result_in} != w_exp);

  // count saturates at the full vector space
  assign w_err_nxt = (w_mis && (r_err != 10'd512))
                   ? r_err + 10'd1 : r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_vec    <= '0;
      r_settle <= '0;
      r_err    <= '0;
      r_ffv    <= 1'b0;
      r_ffvec  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state  <= S_DRIVE;
            r_vec    <= '0;
            r_settle <= '0;
            r_err    <= '0;
            r_ffv    <= 1'b0;
            r_ffvec  <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (r_settle == LP_LAST)
            r_state <= S_CHECK;
          else
            r_settle <= r_settle + 4'd1;
        end
        S_CHECK: begin
          r_err <= w_err_nxt;
          if (w_mis && !r_ffv) begin
            r_ffv   <= 1'b1;
            r_ffvec <= r_vec;
          end
          if (r_vec == 9'd511) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == 10'd0);
          end else begin
            r_vec    <= r_vec + 9'd1;
            r_settle <= '0;
            r_state  <= S_DRIVE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mode_out         = r_vec[8];
  assign bus.a_out            = r_vec[7:4];
  assign bus.b_out            = r_vec[3:0];
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.pass             = r_pass;
  assign bus.err_count        = r_err;
  assign bus.first_fail_valid = r_ffv;
  assign bus.first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_addsub_4bit_bist.sv
// Random-fault and timing bench for addsub_4bit_bist against
// an arithmetic model of the adder/subtractor and its faults.
module tb_addsub_4bit_bist;

  logic clk;
  logic rst_n;
  int   n_tot;
  int   n_bad;

  int         fault;
  logic [4:0] xr [512];

  addsub_4bit_bist_if bus1 ();
  addsub_4bit_bist_if bus3 ();

  addsub_4bit_bist #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  addsub_4bit_bist #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {cout,result} of a correct unit, from plain integer arithmetic
  function automatic logic [4:0] golden(input int v);
    int m, a, b, r, c;
    m = v / 256;
    a = (v / 16) % 16;
    b = v % 16;
    if (m == 0) begin
      r = (a + b) % 16;
      c = (a + b > 15) ? 1 : 0;
    end else begin
      r = (a - b + 16) % 16;
      c = (a >= b) ? 1 : 0;
    end
    return 5'(c * 16 + r);
  endfunction

  logic [8:0] w_v1;
  logic [4:0] w_o1;
  logic [4:0] w_o3;

  always_comb begin
    w_v1 = {bus1.mode_out, bus1.a_out, bus1.b_out};
    w_o1 = golden(int'(w_v1));
    case (fault)
      1: w_o1[4] = 1'b0;
      2: w_o1[0] = ~w_o1[0];
      3: w_o1 = w_o1 ^ xr[w_v1];
      default: ;
    endcase
  end

  always_comb begin
    w_o3 = golden(int'({bus3.mode_out, bus3.a_out, bus3.b_out}));
  end

  assign bus1.result_in = w_o1[3:0];
  assign bus1.cout_in   = w_o1[4];
  assign bus3.result_in = w_o3[3:0];
  assign bus3.cout_in   = w_o3[4];

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic ref_sweep(output int errs, output int first);
    logic [4:0] g, o;
    errs  = 0;
    first = -1;
    for (int v = 0; v < 512; v++) begin
      g = golden(v);
      o = g;
      if (fault == 1) o[4] = 1'b0;
      if (fault == 2) o[0] = ~o[0];
      if (fault == 3) o = o ^ xr[v];
      if (o != g) begin
        errs++;
        if (first < 0) first = v;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ops"}, int'({bus1.mode_out, bus1.a_out, bus1.b_out}), 0);
    chk({tag, "_busy"}, int'(bus1.busy), 0);
    chk({tag, "_done"}, int'(bus1.done), 0);
    chk({tag, "_pass"}, int'(bus1.pass), 0);
    chk({tag, "_err"}, int'(bus1.err_count), 0);
    chk({tag, "_ffv"}, int'(bus1.first_fail_valid), 0);
    chk({tag, "_ffvec"}, int'(bus1.first_fail_vec), 0);
  endtask

  task automatic sweep(input int f, input int poke, input string tag);
    int  exp_err, exp_first, cyc;
    bit  poked;
    fault = f;
    ref_sweep(exp_err, exp_first);
    @(negedge clk) bus1.start = 1'b1;
    @(negedge clk) bus1.start = 1'b0;
    chk({tag, "_busy1"}, int'(bus1.busy), 1);
    chk({tag, "_done0"}, int'(bus1.done), 0);
    chk({tag, "_vec0"},
        int'({bus1.mode_out, bus1.a_out, bus1.b_out}), 0);
    chk({tag, "_clr_err"}, int'(bus1.err_count), 0);
    chk({tag, "_clr_ffv"}, int'(bus1.first_fail_valid), 0);
    cyc   = 0;
    poked = 1'b0;
    while (!bus1.done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      bus1.start = 1'b0;
      if (poke >= 0 && !poked &&
          int'({bus1.mode_out, bus1.a_out, bus1.b_out}) == poke) begin
        bus1.start = 1'b1;
        poked = 1'b1;
      end
    end
    bus1.start = 1'b0;
    chk({tag, "_cycles"}, cyc, 1024);
    chk({tag, "_busy_end"}, int'(bus1.busy), 0);
    chk({tag, "_pass"}, int'(bus1.pass), (exp_err == 0) ? 1 : 0);
    chk({tag, "_err"}, int'(bus1.err_count), exp_err);
    chk({tag, "_ffv"}, int'(bus1.first_fail_valid),
        (exp_first >= 0) ? 1 : 0);
    if (exp_first >= 0)
      chk({tag, "_ffvec"}, int'(bus1.first_fail_vec), exp_first);
    chk({tag, "_ops_hold"},
        int'({bus1.mode_out, bus1.a_out, bus1.b_out}), 511);
  endtask

  task automatic randomize_faults();
    for (int i = 0; i < 512; i++)
      xr[i] = ($urandom_range(0, 7) == 0)
            ? 5'($urandom_range(1, 31)) : 5'd0;
  endtask

  initial begin
    int cyc, last, nchg, nbint;
    logic [8:0] prev, cur;
    n_tot = 0;
    n_bad = 0;
    fault = 0;
    for (int i = 0; i < 512; i++) xr[i] = 5'd0;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;

    sweep(0, -1, "clean");
    sweep(1, -1, "cout0");
    sweep(2, -1, "res0");
    sweep(0, 10, "poke");
    randomize_faults();
    sweep(3, -1, "rnd_a");
    randomize_faults();
    sweep(3, -1, "rnd_b");

    // reset in the middle of a sweep
    fault = 0;
    @(negedge clk) bus1.start = 1'b1;
    @(negedge clk) bus1.start = 1'b0;
    cyc = 0;
    while (int'({bus1.mode_out, bus1.a_out, bus1.b_out}) != 200
           && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach200", int'({bus1.mode_out, bus1.a_out, bus1.b_out}), 200);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stays", int'(bus1.busy), 0);
    sweep(0, -1, "after_rst");

    // slow-settle instance
    @(negedge clk) bus3.start = 1'b1;
    @(negedge clk) bus3.start = 1'b0;
    chk("s3_busy1", int'(bus3.busy), 1);
    cyc   = 0;
    last  = 0;
    nchg  = 0;
    nbint = 0;
    prev  = {bus3.mode_out, bus3.a_out, bus3.b_out};
    while (!bus3.done && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      cur = {bus3.mode_out, bus3.a_out, bus3.b_out};
      if (cur != prev) begin
        if (cyc - last != 4) nbint++;
        last = cyc;
        prev = cur;
        nchg++;
      end
    end
    chk("s3_cycles", cyc, 2048);
    chk("s3_pass", int'(bus3.pass), 1);
    chk("s3_err", int'(bus3.err_count), 0);
    chk("s3_ffv", int'(bus3.first_fail_valid), 0);
    chk("s3_changes", nchg, 511);
    chk("s3_bad_intervals", nbint, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
